ddr3_cmd_responder: RTL and testbench
=====================================

# ddr3_cmd_responder

Synthesizable DDR3 command-bus responder that sits on the memory side of `ddr3_memory_controller`, in place of the external device, for FPGA loopback runs without real RAM. It decodes CKE/CS#/RAS#/CAS#/WE# on each rising edge of the controller's `ck`, and tracks open rows per bank. Write bursts go into a small on-chip store, and read bursts come back after CL. It also flags protocol violations, so the ILA can show controller sequencing bugs.

## Interface
- ADDRESS_BITWIDTH, 14, row/column address width
- BANK_ADDRESS_BITWIDTH, 3, bank address width (8 banks)
- DQ_BITWIDTH, 16, data word width
- STORE_ROW_BITS, 2, low row bits kept in store
- STORE_COL_BITS, 5, low column bits kept in store
- BURST_LEN, 8, words per burst (one word per ck period)
- CL, 5, read latency in ck periods
- CWL, 5, write latency in ck periods

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  master clock; all logic on its rising edge
- resetn  in  1  synchronous active-low reset
- ck  in  1  controller DDR clock, sampled in the clk domain
- reset_n  in  1  DDR reset; low clears bank state, keeps store contents
- ck_en, cs_n, ras_n, cas_n, we_n  in  1 each  command bus
- bank_address  in  BANK_ADDRESS_BITWIDTH  bank
- address  in  ADDRESS_BITWIDTH  row (ACT) / column (RD/WR); A10 = all-banks on PRE
- dq_in  in  DQ_BITWIDTH  write data from controller
- dq_out  out  DQ_BITWIDTH  read data
- dq_oe  out  1  read data valid / drive enable
- protocol_error  out  1  sticky violation flag
- error_code  out  3  code of the first violation
- refresh_count  out  16  saturating REF counter

## Operation
- ck_rise = ck & ~ck_q, where ck_q is ck registered in clk. All decoding and all burst counters advance only on ck_rise cycles.
- A command is valid when ck_en=1 and cs_n=0 on a ck_rise. {ras_n,cas_n,we_n} decodes as:
  - 011 ACT
  - 101 READ
  - 100 WRITE
  - 010 PRE
  - 001 REF
  - 000 MRS (ignored)
  - 111 NOP
- Per-bank state: open_flag[8] and open_row[8] (the STORE_ROW_BITS low bits only).
- ACT on a closed bank opens it. ACT on an open bank is error 1.
- PRE closes the addressed bank; with A10=1 it closes all banks. PRE on a closed bank is legal.
- REF with any bank open is error 2 and is otherwise ignored. A legal REF increments refresh_count, which saturates at 16'hFFFF.
- READ/WRITE to a closed bank is error 3; the command is dropped.
- READ/WRITE while the FSM is not IDLE is error 4; the command is dropped.
- Store address = {bank, open_row[bank], column[STORE_COL_BITS-1:0]}. The low log2(BURST_LEN) column bits are forced to 0, and the word index is added within the burst.
- FSM states and transitions:
  - IDLE: WRITE goes to WR_WAIT; READ goes to RD_WAIT. Bank, row and column are latched.
  - WR_WAIT: counts CWL ck_rises, then goes to WR_BURST.
  - WR_BURST: on each of BURST_LEN ck_rises, stores dq_in at base+i; after the last one, returns to IDLE.
  - RD_WAIT: counts CL ck_rises, then goes to RD_BURST.
  - RD_BURST: on each of BURST_LEN ck_rises, loads dq_out with store[base+i] and holds dq_oe=1; after the last one, returns to IDLE with dq_oe=0.
- protocol_error sets on the first violation and is cleared only by resetn. error_code latches the first code; later violations do not overwrite it.
- reset_n=0 (DDR reset) closes all banks and returns the FSM to IDLE with dq_oe=0. It does not touch protocol_error, refresh_count or the store.

## Timing
- Reset (resetn=0): FSM=IDLE, all banks closed, dq_out=0, dq_oe=0, protocol_error=0, error_code=0, refresh_count=0, ck_q=0. Store contents are undefined.
- Command decode occurs in the clk cycle where ck_rise=1, i.e. one clk after ck rises.
- Write word i is sampled on the (CWL+1+i)-th ck_rise after the WRITE ck_rise.
- Read word i appears on the (CL+1+i)-th ck_rise after the READ ck_rise and holds until the next ck_rise. dq_oe is high for exactly BURST_LEN ck periods.
- Commands arriving during a burst are still decoded for ACT/PRE/REF bank state; only READ/WRITE is rejected.
- resetn=0 mid-burst aborts it: the partial write is kept in the store, and dq_oe falls on the next clk.
- Column wrap inside a burst uses STORE_COL_BITS modulo arithmetic; no carry into the row bits.

## Test plan
- ACT bank 2 row 1; WRITE col 8 with words 0x0000..0x0007; READ col 8 -> dq_oe high 8 ck periods starting 6 ck_rises after READ, with dq_out 0x0000..0x0007 in order.
- READ to bank 5 while it is closed -> protocol_error=1, error_code=3, dq_oe stays 0.
- ACT bank 0 twice; then a second ACT on bank 1 -> error_code stays 1 (first error kept).
- PRE with A10=1 after opening banks 0,3,7, then REF ×3 -> refresh_count=3, no error. A REF while bank 4 is open -> error_code=2, count unchanged.
- WRITE issued during the RD_BURST of a prior READ -> error_code=4, and the store at the write address is unchanged on readback.
- reset_n pulsed low mid-read burst -> dq_oe=0 next clk, all banks closed; a later READ to any bank -> error 3; refresh_count is preserved.

Source files
------------

// File: rtl/ddr3_cmd_responder_if.sv
// DDR3 command/data bus between ddr3_memory_controller (master) and the
// loopback command responder (slave), plus the responder's debug status.
interface ddr3_cmd_responder_if #(
    parameter int ADDRESS_BITWIDTH      = 14,
    parameter int BANK_ADDRESS_BITWIDTH = 3,
    parameter int DQ_BITWIDTH           = 16
);
    logic                             ck;
    logic                             reset_n;
    logic                             ck_en;
    logic                             cs_n;
    logic                             ras_n;
    logic                             cas_n;
    logic                             we_n;
    logic [BANK_ADDRESS_BITWIDTH-1:0] bank_address;
    logic [ADDRESS_BITWIDTH-1:0]      address;
    logic [DQ_BITWIDTH-1:0]           dq_in;
    logic [DQ_BITWIDTH-1:0]           dq_out;
    logic                             dq_oe;
    logic                             protocol_error;
    logic [2:0]                       error_code;
    logic [15:0]                      refresh_count;

    modport master (
        output ck, reset_n, ck_en, cs_n, ras_n, cas_n, we_n,
        output bank_address, address, dq_in,
        input  dq_out, dq_oe, protocol_error, error_code, refresh_count
    );

    modport slave (
        input  ck, reset_n, ck_en, cs_n, ras_n, cas_n, we_n,
        input  bank_address, address, dq_in,
        output dq_out, dq_oe, protocol_error, error_code, refresh_count
    );
endinterface

// File: rtl/ddr3_cmd_responder.sv
// Stand-in for a DDR3 device on FPGA loopback runs: decodes the command bus on
// ck rising edges, tracks open banks, stores write bursts and replays reads.
module ddr3_cmd_responder #(
    parameter int ADDRESS_BITWIDTH      = 14,
    parameter int BANK_ADDRESS_BITWIDTH = 3,
    parameter int DQ_BITWIDTH           = 16,
    parameter int STORE_ROW_BITS        = 2,
    parameter int STORE_COL_BITS        = 5,
    parameter int BURST_LEN             = 8,
    parameter int CL                    = 5,
    parameter int CWL                   = 5
) (
    input  logic                clk,
    input  logic                resetn,
    ddr3_cmd_responder_if.slave bus
);
    localparam int BANKS           = 1 << BANK_ADDRESS_BITWIDTH;
    localparam int BEAT_BITS       = $clog2(BURST_LEN);
    localparam int STORE_ADDR_BITS = BANK_ADDRESS_BITWIDTH + STORE_ROW_BITS + STORE_COL_BITS;
    localparam int STORE_DEPTH     = 1 << STORE_ADDR_BITS;

    localparam logic [7:0]                CL_LAST   = 8'(CL - 1);
    localparam logic [7:0]                CWL_LAST  = 8'(CWL - 1);
    localparam logic [BEAT_BITS-1:0]      BEAT_LAST = BEAT_BITS'(BURST_LEN - 1);
    localparam logic [STORE_COL_BITS-1:0] COL_MASK  = ~STORE_COL_BITS'(BURST_LEN - 1);

    localparam logic [2:0] CMD_ACT   = 3'b011;
    localparam logic [2:0] CMD_READ  = 3'b101;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam logic [2:0] CMD_REF   = 3'b001;

    localparam logic [2:0] ERR_ACT_OPEN = 3'd1;
    localparam logic [2:0] ERR_REF_OPEN = 3'd2;
    localparam logic [2:0] ERR_CLOSED   = 3'd3;
    localparam logic [2:0] ERR_BUSY     = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_WAIT,
        S_WR_BURST,
        S_RD_WAIT,
        S_RD_BURST
    } state_t;

    logic                             r_ck_q;
    logic                             w_ck_rise;
    logic                             w_cmd_valid;
    logic [2:0]                       w_cmd;
    logic                             w_is_act;
    logic                             w_is_rd;
    logic                             w_is_wr;
    logic                             w_is_pre;
    logic                             w_is_ref;
    logic [BANK_ADDRESS_BITWIDTH-1:0] w_bank;
    logic                             w_bank_open;
    logic                             w_any_open;
    logic                             w_err_valid;
    logic [2:0]                       w_err_code;
    logic                             w_accept_rw;
    logic                             w_store_we;
    logic [STORE_ADDR_BITS-1:0]       w_store_addr;
    logic                             w_unused_bits;

    logic [BANKS-1:0]                 r_open_flag;
    logic [STORE_ROW_BITS-1:0]        r_open_row [BANKS];

    state_t                           r_state;
    logic [7:0]                       r_wait_cnt;
    logic [BEAT_BITS-1:0]             r_beat;
    logic [BANK_ADDRESS_BITWIDTH-1:0] r_bank;
    logic [STORE_ROW_BITS-1:0]        r_row;
    logic [STORE_COL_BITS-1:0]        r_col;
    logic [DQ_BITWIDTH-1:0]           r_dq_out;
    logic                             r_dq_oe;

    logic                             r_protocol_error;
    logic [2:0]                       r_error_code;
    logic [15:0]                      r_refresh_count;

    logic [DQ_BITWIDTH-1:0]           r_store [STORE_DEPTH];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ck_q <= 1'b0;
        end else begin
            r_ck_q <= bus.ck;
        end
    end

    // Commands are ignored entirely while the DDR reset pin is held low.
    assign w_ck_rise   = bus.ck & ~r_ck_q;
    assign w_cmd_valid = w_ck_rise & bus.ck_en & ~bus.cs_n & bus.reset_n;
    assign w_cmd       = {bus.ras_n, bus.cas_n, bus.we_n};
    assign w_is_act    = w_cmd_valid && (w_cmd == CMD_ACT);
    assign w_is_rd     = w_cmd_valid && (w_cmd == CMD_READ);
    assign w_is_wr     = w_cmd_valid && (w_cmd == CMD_WRITE);
    assign w_is_pre    = w_cmd_valid && (w_cmd == CMD_PRE);
    assign w_is_ref    = w_cmd_valid && (w_cmd == CMD_REF);
    assign w_bank      = bus.bank_address;
    assign w_bank_open = r_open_flag[w_bank];
    assign w_any_open  = |r_open_flag;
    assign w_accept_rw = (w_is_rd || w_is_wr) && w_bank_open && (r_state == S_IDLE);

    assign w_unused_bits = ^{bus.address[ADDRESS_BITWIDTH-1:11], bus.address[9:STORE_COL_BITS]};

    always_comb begin
        w_err_valid = 1'b0;
        w_err_code  = 3'd0;
        if (w_is_act && w_bank_open) begin
            w_err_valid = 1'b1;
            w_err_code  = ERR_ACT_OPEN;
        end else if (w_is_ref && w_any_open) begin
            w_err_valid = 1'b1;
            w_err_code  = ERR_REF_OPEN;
        end else if ((w_is_rd || w_is_wr) && !w_bank_open) begin
            w_err_valid = 1'b1;
            w_err_code  = ERR_CLOSED;
        end else if ((w_is_rd || w_is_wr) && (r_state != S_IDLE)) begin
            w_err_valid = 1'b1;
            w_err_code  = ERR_BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_open_flag <= '0;
            for (int b = 0; b < BANKS; b++) begin
                r_open_row[b] <= '0;
            end
        end else if (!bus.reset_n) begin
            r_open_flag <= '0;
        end else begin
            if (w_is_act && !w_bank_open) begin
                r_open_flag[w_bank] <= 1'b1;
                r_open_row[w_bank]  <= bus.address[STORE_ROW_BITS-1:0];
            end
            if (w_is_pre) begin
                if (bus.address[10]) begin
                    r_open_flag <= '0;
                end else begin
                    r_open_flag[w_bank] <= 1'b0;
                end
            end
        end
    end

    // Burst column wraps modulo the stored column range, never carrying into the row.
    assign w_store_addr = {r_bank, r_row, r_col + STORE_COL_BITS'(r_beat)};
    assign w_store_we   = resetn && bus.reset_n && w_ck_rise && (r_state == S_WR_BURST);

    always_ff @(posedge clk) begin
        if (w_store_we) begin
            r_store[w_store_addr] <= bus.dq_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_beat     <= '0;
            r_bank     <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_dq_out   <= '0;
            r_dq_oe    <= 1'b0;
        end else if (!bus.reset_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_beat     <= '0;
            r_dq_oe    <= 1'b0;
        end else if (w_ck_rise) begin
            case (r_state)
                S_IDLE: begin
                    r_dq_oe <= 1'b0;
                    if (w_accept_rw) begin
                        r_state    <= w_is_wr ? S_WR_WAIT : S_RD_WAIT;
                        r_bank     <= w_bank;
                        r_row      <= r_open_row[w_bank];
                        r_col      <= bus.address[STORE_COL_BITS-1:0] & COL_MASK;
                        r_wait_cnt <= '0;
                        r_beat     <= '0;
                    end
                end
                S_WR_WAIT: begin
                    if (r_wait_cnt == CWL_LAST) begin
                        r_state    <= S_WR_BURST;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_WR_BURST: begin
                    if (r_beat == BEAT_LAST) begin
                        r_state <= S_IDLE;
                        r_beat  <= '0;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                S_RD_WAIT: begin
                    if (r_wait_cnt == CL_LAST) begin
                        r_state    <= S_RD_BURST;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                // The last word stays on dq_out until IDLE drops dq_oe at the next ck rise.
                S_RD_BURST: begin
                    r_dq_out <= r_store[w_store_addr];
                    r_dq_oe  <= 1'b1;
                    if (r_beat == BEAT_LAST) begin
                        r_state <= S_IDLE;
                        r_beat  <= '0;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_protocol_error <= 1'b0;
            r_error_code     <= 3'd0;
            r_refresh_count  <= 16'd0;
        end else begin
            if (w_err_valid && !r_protocol_error) begin
                r_protocol_error <= 1'b1;
                r_error_code     <= w_err_code;
            end
            if (w_is_ref && !w_any_open && (r_refresh_count != 16'hFFFF)) begin
                r_refresh_count <= r_refresh_count + 16'd1;
            end
        end
    end

    assign bus.dq_out         = r_dq_out;
    assign bus.dq_oe          = r_dq_oe;
    assign bus.protocol_error = r_protocol_error;
    assign bus.error_code     = r_error_code;
    assign bus.refresh_count  = r_refresh_count;
endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// Scoreboard bench for ddr3_cmd_responder: directed command sequences, read
// words checked by an independent monitor against queued expectations.
module tb_ddr3_cmd_responder;
    localparam int CL        = 5;
    localparam int CWL       = 5;
    localparam int BURST_LEN = 8;

    localparam logic [2:0] CMD_ACT   = 3'b011;
    localparam logic [2:0] CMD_READ  = 3'b101;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam logic [2:0] CMD_REF   = 3'b001;
    localparam logic [2:0] CMD_NOP   = 3'b111;

    typedef struct {
        int          rise;
        logic [15:0] data;
    } exp_t;

    logic clk;
    logic resetn;
    int   testsRun;
    int   testsFailed;
    int   tickCount;
    int   riseIdx;
    exp_t sbQ[$];

    ddr3_cmd_responder_if #(
        .ADDRESS_BITWIDTH(14),
        .BANK_ADDRESS_BITWIDTH(3),
        .DQ_BITWIDTH(16)
    ) bus ();

    ddr3_cmd_responder #(
        .ADDRESS_BITWIDTH(14),
        .BANK_ADDRESS_BITWIDTH(3),
        .DQ_BITWIDTH(16),
        .STORE_ROW_BITS(2),
        .STORE_COL_BITS(5),
        .BURST_LEN(BURST_LEN),
        .CL(CL),
        .CWL(CWL)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One ck period (four clk cycles) carrying a single command.
    task automatic applyStimulus(input logic [2:0] cmd, input logic [2:0] ba, input logic [13:0] addr,
                                 input logic [15:0] dq);
        tickCount++;
        {bus.ras_n, bus.cas_n, bus.we_n} = cmd;
        bus.bank_address = ba;
        bus.address      = addr;
        bus.dq_in        = dq;
        bus.ck           = 1'b1;
        repeat (2) @(negedge clk);
        bus.ck = 1'b0;
        {bus.ras_n, bus.cas_n, bus.we_n} = CMD_NOP;
        repeat (2) @(negedge clk);
    endtask

    task automatic nop(input int n, input logic [15:0] dq);
        for (int k = 0; k < n; k++) begin
            applyStimulus(CMD_NOP, 3'd0, 14'd0, dq);
        end
    endtask

    task automatic doWrite(input logic [2:0] ba, input logic [13:0] col, input logic [15:0] base);
        applyStimulus(CMD_WRITE, ba, col, 16'h0);
        nop(CWL, 16'h0);
        for (int k = 0; k < BURST_LEN; k++) begin
            applyStimulus(CMD_NOP, 3'd0, 14'd0, 16'(base + k));
        end
    endtask

    task automatic issueRead(input logic [2:0] ba, input logic [13:0] col, input logic [15:0] base,
                             input int nWords);
        exp_t e;
        applyStimulus(CMD_READ, ba, col, 16'h0);
        for (int k = 0; k < nWords; k++) begin
            e.rise = tickCount + CL + 1 + k;
            e.data = 16'(base + k);
            sbQ.push_back(e);
        end
    endtask

    task automatic resetDut();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: tracks ck rises independently and compares every driven read word.
    initial begin
        logic monCkQ;
        logic isRise;
        exp_t e;
        monCkQ  = 1'b0;
        riseIdx = 0;
        forever begin
            @(posedge clk);
            isRise = resetn && bus.ck && !monCkQ;
            monCkQ = resetn ? bus.ck : 1'b0;
            if (isRise) begin
                riseIdx++;
                #1;
                if (bus.dq_oe === 1'b1) begin
                    testsRun++;
                    if (sbQ.size() == 0) begin
                        testsFailed++;
                        $display("[TB] FAIL unexpected dq_oe: data 0x%0h at rise %0d, expected no read data",
                                 bus.dq_out, riseIdx);
                    end else begin
                        e = sbQ.pop_front();
                        if (e.rise != riseIdx || bus.dq_out !== e.data) begin
                            testsFailed++;
                            $display("[TB] FAIL read word: got 0x%0h at rise %0d, expected 0x%0h at rise %0d",
                                     bus.dq_out, riseIdx, e.data, e.rise);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        tickCount   = 0;
        resetn      = 1'b0;
        bus.ck      = 1'b0;
        bus.reset_n = 1'b1;
        bus.ck_en   = 1'b1;
        bus.cs_n    = 1'b0;
        {bus.ras_n, bus.cas_n, bus.we_n} = CMD_NOP;
        bus.bank_address = 3'd0;
        bus.address      = 14'd0;
        bus.dq_in        = 16'h0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        $display("[TB] reset values");
        checkOutput("reset protocol_error", 32'(bus.protocol_error), 32'd0);
        checkOutput("reset error_code", 32'(bus.error_code), 32'd0);
        checkOutput("reset refresh_count", 32'(bus.refresh_count), 32'd0);
        checkOutput("reset dq_oe", 32'(bus.dq_oe), 32'd0);
        checkOutput("reset dq_out", 32'(bus.dq_out), 32'd0);

        $display("[TB] write then read back, bank 2 row 1");
        applyStimulus(CMD_ACT, 3'd2, 14'd1, 16'h0);
        doWrite(3'd2, 14'd8, 16'h0000);
        issueRead(3'd2, 14'd8, 16'h0000, BURST_LEN);
        nop(5, 16'h0);
        checkOutput("dq_oe low during CL", 32'(bus.dq_oe), 32'd0);
        nop(9, 16'h0);
        checkOutput("dq_oe low after burst", 32'(bus.dq_oe), 32'd0);
        doWrite(3'd2, 14'd21, 16'hA5A0);
        issueRead(3'd2, 14'd19, 16'hA5A0, BURST_LEN);
        nop(14, 16'h0);
        checkOutput("no error on legal traffic", 32'(bus.protocol_error), 32'd0);
        checkOutput("scoreboard drained rw", 32'(sbQ.size()), 32'd0);

        $display("[TB] read to closed bank");
        resetDut();
        applyStimulus(CMD_READ, 3'd5, 14'd0, 16'h0);
        checkOutput("closed read protocol_error", 32'(bus.protocol_error), 32'd1);
        checkOutput("closed read error_code", 32'(bus.error_code), 32'd3);
        nop(14, 16'h0);
        checkOutput("closed read dq_oe", 32'(bus.dq_oe), 32'd0);

        $display("[TB] first error is kept");
        resetDut();
        applyStimulus(CMD_ACT, 3'd0, 14'd0, 16'h0);
        applyStimulus(CMD_ACT, 3'd0, 14'd0, 16'h0);
        checkOutput("double ACT error_code", 32'(bus.error_code), 32'd1);
        applyStimulus(CMD_ACT, 3'd1, 14'd0, 16'h0);
        applyStimulus(CMD_ACT, 3'd1, 14'd0, 16'h0);
        applyStimulus(CMD_READ, 3'd6, 14'd0, 16'h0);
        checkOutput("later errors keep code", 32'(bus.error_code), 32'd1);
        checkOutput("sticky protocol_error", 32'(bus.protocol_error), 32'd1);

        $display("[TB] precharge all then refresh");
        resetDut();
        applyStimulus(CMD_ACT, 3'd0, 14'd0, 16'h0);
        applyStimulus(CMD_ACT, 3'd3, 14'd0, 16'h0);
        applyStimulus(CMD_ACT, 3'd7, 14'd0, 16'h0);
        applyStimulus(CMD_PRE, 3'd0, 14'h0400, 16'h0);
        applyStimulus(CMD_REF, 3'd0, 14'd0, 16'h0);
        applyStimulus(CMD_REF, 3'd0, 14'd0, 16'h0);
        applyStimulus(CMD_REF, 3'd0, 14'd0, 16'h0);
        checkOutput("refresh_count after 3 REF", 32'(bus.refresh_count), 32'd3);
        checkOutput("no error after PRE all", 32'(bus.protocol_error), 32'd0);
        applyStimulus(CMD_ACT, 3'd4, 14'd0, 16'h0);
        applyStimulus(CMD_REF, 3'd0, 14'd0, 16'h0);
        checkOutput("REF with open bank code", 32'(bus.error_code), 32'd2);
        checkOutput("REF with open bank count", 32'(bus.refresh_count), 32'd3);

        $display("[TB] write during read burst");
        resetDut();
        applyStimulus(CMD_ACT, 3'd1, 14'd2, 16'h0);
        doWrite(3'd1, 14'd0, 16'h1100);
        issueRead(3'd1, 14'd0, 16'h1100, BURST_LEN);
        nop(6, 16'h0);
        applyStimulus(CMD_WRITE, 3'd1, 14'd0, 16'hDEAD);
        checkOutput("busy write error_code", 32'(bus.error_code), 32'd4);
        nop(7, 16'hDEAD);
        issueRead(3'd1, 14'd0, 16'h1100, BURST_LEN);
        nop(14, 16'hDEAD);
        checkOutput("scoreboard drained busy", 32'(sbQ.size()), 32'd0);

        $display("[TB] DDR reset mid read burst");
        resetDut();
        applyStimulus(CMD_REF, 3'd0, 14'd0, 16'h0);
        applyStimulus(CMD_REF, 3'd0, 14'd0, 16'h0);
        applyStimulus(CMD_ACT, 3'd2, 14'd1, 16'h0);
        issueRead(3'd2, 14'd8, 16'h0000, 3);
        nop(8, 16'h0);
        checkOutput("dq_oe mid burst", 32'(bus.dq_oe), 32'd1);
        bus.reset_n = 1'b0;
        @(negedge clk);
        checkOutput("dq_oe after DDR reset", 32'(bus.dq_oe), 32'd0);
        bus.reset_n = 1'b1;
        @(negedge clk);
        applyStimulus(CMD_READ, 3'd2, 14'd8, 16'h0);
        checkOutput("banks closed by DDR reset", 32'(bus.error_code), 32'd3);
        checkOutput("refresh_count preserved", 32'(bus.refresh_count), 32'd2);
        nop(14, 16'h0);
        checkOutput("dq_oe stays low", 32'(bus.dq_oe), 32'd0);
        checkOutput("scoreboard drained abort", 32'(sbQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
